// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins plus the decoded key and entry-register outputs.
// The scanner connects through the slave modport; the keypad/host side uses master.
interface keypad_if;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] value;

  modport master (
    output row, clear,
    input  col, key_code, key_valid, key_held, value
  );

  modport slave (
    input  row, clear,
    output col, key_code, key_valid, key_held, value
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scan, press/release debounce, 4-digit entry register.
// Held-key auto-repeat is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic     clk,
  input logic     reset,
  keypad_if.slave kp
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t            state, state_n;
  logic [1:0]        ci, ci_n;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_n;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_n;
  logic [1:0]        key_r, key_r_n;
  logic [1:0]        key_c, key_c_n;
  logic              accept;
  logic [3:0]        row_sync_p0, row_sync_p1;
  logic [3:0]        row_s;
  logic              key_up;
  logic [3:0]        accept_code;
  logic [3:0]        key_code;
  logic              key_valid;
  logic [15:0]       value;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYCLES;
`endif

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign row_s       = row_sync_p1;
  assign key_up      = row_s[key_r];
  assign accept_code = key_map(key_r, key_c);

  // The scan counter only runs in SCAN, so every column visit starts from a full dwell.
  always_comb begin
    state_n    = state;
    ci_n       = ci;
    scan_cnt_n = '0;
    deb_cnt_n  = deb_cnt;
    key_r_n    = key_r;
    key_c_n    = key_c;
    accept     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n  = rep_cnt;
`endif
    unique case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          if (row_s != 4'hF) begin
            state_n   = DEBOUNCE;
            key_r_n   = lowest_low(row_s);
            key_c_n   = ci;
            deb_cnt_n = '0;
          end else begin
            ci_n = ci + 2'd1;
          end
        end else begin
          scan_cnt_n = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (key_up) begin
          state_n = SCAN;
          ci_n    = ci + 2'd1;
        end else if (deb_cnt == DEB_LAST) begin
          state_n = HELD;
          accept  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_n = '0;
`endif
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (key_up) begin
          state_n   = RELEASE;
          deb_cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_n = '0;
        end else if (rep_cnt == REP_LAST) begin
          accept    = 1'b1;
          rep_cnt_n = '0;
        end else begin
          rep_cnt_n = rep_cnt + 1'b1;
`endif
        end
      end
      RELEASE: begin
        // A single low cycle means the contact bounced; go back without a new strobe.
        if (!key_up) begin
          state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
          rep_cnt_n = '0;
`endif
        end else if (deb_cnt == DEB_LAST) begin
          state_n = SCAN;
          ci_n    = ci + 2'd1;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
    endcase
  end

  // Stage p0/p1: two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_sync_p0 <= 4'hF;
      row_sync_p1 <= 4'hF;
      state       <= SCAN;
      ci          <= 2'd0;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      key_r       <= 2'd0;
      key_c       <= 2'd0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      value       <= 16'h0000;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      row_sync_p0 <= kp.row;
      row_sync_p1 <= row_sync_p0;
      state       <= state_n;
      ci          <= ci_n;
      scan_cnt    <= scan_cnt_n;
      deb_cnt     <= deb_cnt_n;
      key_r       <= key_r_n;
      key_c       <= key_c_n;
      key_valid   <= accept;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt     <= rep_cnt_n;
`endif
      if (accept) begin
        key_code <= accept_code;
      end
      if (kp.clear) begin
        value <= 16'h0000;
      end else if (accept) begin
        value <= {value[11:0], accept_code};
      end
    end
  end

  assign kp.col       = ~(4'b0001 << ci);
  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_held  = (state == HELD) || (state == RELEASE);
  assign kp.value     = value;

endmodule
